muldiv_ctrl: RTL and testbench



---
 rtl/muldiv_pkg.sv | 18 +
 rtl/muldiv_ctrl_div_core.sv | 67 ++++++
 rtl/muldiv_ctrl.sv | 143 ++++++++++++++
 tb/tb_muldiv_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

  localparam int unsigned DIV_ITERS = 32;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/muldiv_ctrl_div_core.sv
// Unsigned restoring shift-subtract divider; one quotient bit per step.
module div_core
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             last_c,
  output logic [WIDTH-1:0] rem_c,
  output logic [WIDTH-1:0] quo_c
);

  localparam int unsigned CNT_W = $clog2(DIV_ITERS);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   trial;
  logic             fits;

  // Result of the current iteration, exposed so the caller can capture the final bit.
  always_comb begin
    trial  = {rem_q, quo_q[WIDTH-1]};
    fits   = trial >= {1'b0, dvs_q};
    rem_c  = fits ? WIDTH'(trial - {1'b0, dvs_q}) : trial[WIDTH-1:0];
    quo_c  = {quo_q[WIDTH-2:0], fits};
    last_c = (cnt_q == CNT_W'(DIV_ITERS - 1));
  end

  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    if (load) begin
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
      cnt_d = '0;
    end else if (step) begin
      rem_d = rem_c;
      quo_d = quo_c;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage HI/LO sequencer: one-cycle multiply, 32-step divide, stall and write strobe.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             stall,
  output logic             busy,
  output logic             hilo_we,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             signed_q, signed_d;
  logic             neg_q, neg_d;
  logic             asign_q, asign_d;

  logic             signed_op, is_div;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [2*WIDTH-1:0] mul_ax, mul_bx, prod;
  logic             div_load, div_step, div_last;
  logic [WIDTH-1:0] div_rem, div_quo;

  div_core #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .step     (div_step),
    .dividend (a_mag),
    .divisor  (b_mag),
    .last_c   (div_last),
    .rem_c    (div_rem),
    .quo_c    (div_quo)
  );

  // Operand decode and magnitudes for the divider, taken straight from EX in the accept cycle.
  always_comb begin
    signed_op = (op == MD_MULT) || (op == MD_DIV);
    is_div    = (op == MD_DIV) || (op == MD_DIVU);
    a_mag     = (signed_op && a[WIDTH-1]) ? -a : a;
    b_mag     = (signed_op && b[WIDTH-1]) ? -b : b;
    mul_ax    = signed_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    mul_bx    = signed_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod      = mul_ax * mul_bx;
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    signed_d = signed_q;
    neg_d    = neg_q;
    asign_d  = asign_q;
    div_load = 1'b0;
    div_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !cancel) begin
          a_d      = a;
          b_d      = b;
          signed_d = signed_op;
          if (!is_div) begin
            state_d = ST_MUL;
          end else if (b == '0) begin
            hi_d    = a;
            lo_d    = '1;
            state_d = ST_DONE;
          end else begin
            div_load = 1'b1;
            neg_d    = signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
            asign_d  = signed_op && a[WIDTH-1];
            state_d  = ST_DIV;
          end
        end
      end
      ST_MUL: begin
        if (cancel) begin
          state_d = ST_IDLE;
        end else begin
          {hi_d, lo_d} = prod;
          state_d      = ST_DONE;
        end
      end
      ST_DIV: begin
        if (cancel) begin
          state_d = ST_IDLE;
        end else begin
          div_step = 1'b1;
          // Final bit arrives this cycle, so the sign fix works on the core's next value.
          if (div_last) begin
            lo_d    = neg_q ? -div_quo : div_quo;
            hi_d    = asign_q ? -div_rem : div_rem;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      signed_q <= 1'b0;
      neg_q    <= 1'b0;
      asign_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      signed_q <= signed_d;
      neg_q    <= neg_d;
      asign_q  <= asign_d;
    end
  end

  assign stall   = ((state_q == ST_IDLE) && start && !cancel) ||
                   (state_q == ST_MUL) || (state_q == ST_DIV);
  assign busy    = (state_q != ST_IDLE);
  assign hilo_we = (state_q == ST_DONE) && !cancel;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized and directed checks of muldiv_ctrl against a 64-bit arithmetic reference.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        cancel;
  logic        stall, busy, hilo_we;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  muldiv_ctrl #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .cancel  (cancel),
    .stall   (stall),
    .busy    (busy),
    .hilo_we (hilo_we),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  // Reference: latency in cycles after the accept cycle, plus HI/LO from wide arithmetic.
  function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                output int lat, output logic [31:0] eh, output logic [31:0] el);
    longint sa, sb, sq, sr;
    logic [63:0] p, wq, wr;
    sa = longint'($signed(x));
    sb = longint'($signed(y));
    lat = 2;
    eh  = '0;
    el  = '0;
    case (o)
      2'b00: begin p = 64'(sa * sb); eh = p[63:32]; el = p[31:0]; end
      2'b01: begin p = {32'b0, x} * {32'b0, y}; eh = p[63:32]; el = p[31:0]; end
      default: begin
        if (y == 32'd0) begin
          lat = 1; eh = x; el = 32'hFFFF_FFFF;
        end else begin
          lat = 33;
          if (o == 2'b10) begin
            sq = sa / sb; sr = sa % sb;
            wq = 64'(sq); wr = 64'(sr);
            el = wq[31:0]; eh = wr[31:0];
          end else begin
            el = x / y; eh = x % y;
          end
        end
      end
    endcase
  endfunction

  task automatic do_op(input string name, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y);
    int lat, seen, bad;
    logic [31:0] eh, el;
    model(o, x, y, lat, eh, el);
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL %s accept_stall got %b want 1", name, stall);
    end
    seen = 0; bad = 0;
    for (int k = 1; k <= 40 && seen == 0; k++) begin
      @(posedge clk); #1;
      if (hilo_we === 1'b1) begin
        seen = k; start = 1'b0;
      end else if (stall !== 1'b1) begin
        bad++;
      end
    end
    start = 1'b0;
    checks++;
    if (seen != lat) begin
      errors++; $display("FAIL %s latency got %0d want %0d", name, seen, lat);
    end
    checks++;
    if (bad != 0 || stall !== 1'b0) begin
      errors++; $display("FAIL %s stall_window bad_cycles %0d done_stall %b want 0/0", name, bad, stall);
    end
    checks++;
    if (hi !== eh || lo !== el) begin
      errors++;
      $display("FAIL %s result got hi=%h lo=%h want hi=%h lo=%h (a=%h b=%h)", name, hi, lo, eh, el, x, y);
    end
    exp_hi = eh;
    exp_lo = el;
  endtask

  task automatic test_reset();
    checks++;
    if (stall !== 1'b0 || busy !== 1'b0 || hilo_we !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_state got stall=%b busy=%b we=%b hi=%h lo=%h want all 0", stall, busy, hilo_we, hi, lo);
    end
  endtask

  task automatic test_directed();
    do_op("mult_neg3x5", 2'b00, 32'hFFFF_FFFD, 32'd5);
    do_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
    do_op("divu_100_7", 2'b11, 32'd100, 32'd7);
    do_op("div_by_zero", 2'b10, 32'h1234_5678, 32'd0);
    do_op("divu_by_zero", 2'b11, 32'h8765_4321, 32'd0);
    do_op("div_overflow", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("div_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE);
  endtask

  task automatic test_cancel();
    logic [31:0] ph, pl;
    int we_seen;
    ph = exp_hi; pl = exp_lo; we_seen = 0;
    @(posedge clk); #1;
    start = 1'b1; op = 2'b11; a = 32'd1000; b = 32'd3;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (hilo_we === 1'b1) we_seen++;
    end
    cancel = 1'b1; start = 1'b0;
    #1;
    if (hilo_we === 1'b1) we_seen++;
    @(posedge clk); #1;
    cancel = 1'b0;
    checks++;
    if (busy !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL cancel_div_idle got busy=%b stall=%b want 0/0", busy, stall);
    end
    checks++;
    if (we_seen != 0 || hilo_we !== 1'b0 || hi !== ph || lo !== pl) begin
      errors++;
      $display("FAIL cancel_div_hold got we_count=%0d hi=%h lo=%h want 0 hi=%h lo=%h", we_seen, hi, lo, ph, pl);
    end
    do_op("mult_after_cancel", 2'b00, 32'd12345, 32'hFFFF_FF00);

    // Start with cancel in IDLE is not accepted.
    @(posedge clk); #1;
    start = 1'b1; cancel = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL idle_cancel_stall got %b want 0", stall);
    end
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL idle_cancel_busy got %b want 0", busy);
    end

    // Cancel in DONE suppresses the write strobe.
    @(posedge clk); #1;
    start = 1'b1; op = 2'b01; a = 32'd6; b = 32'd7;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cancel = 1'b1; start = 1'b0;
    #1;
    checks++;
    if (hilo_we !== 1'b0 || stall !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL done_cancel got we=%b stall=%b busy=%b want 0/0/1", hilo_we, stall, busy);
    end
    @(posedge clk); #1;
    cancel = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL done_cancel_idle got busy=%b want 0", busy);
    end
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] x, y;
    int sel;
    for (int i = 0; i < 24; i++) begin
      o   = 2'($urandom_range(0, 3));
      x   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0)      y = 32'd0;
      else if (sel <= 3) y = $urandom_range(1, 17);
      else if (sel == 4) y = 32'hFFFF_FFFF;
      else               y = $urandom;
      if ($urandom_range(0, 5) == 0) x = 32'h8000_0000;
      do_op("random", o, x, y);
    end
  endtask

  task automatic test_back_to_back();
    do_op("b2b_div", 2'b10, 32'hFFFF_FC18, 32'd37);
    do_op("b2b_mult", 2'b00, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    do_op("b2b_divu", 2'b11, 32'hFFFF_FFFF, 32'd16);
  endtask

  task automatic test_reset_mid();
    int we_seen;
    we_seen = 0;
    @(posedge clk); #1;
    start = 1'b1; op = 2'b10; a = 32'hFFFF_FFF9; b = 32'd2;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
    end
    #2;
    rst = 1'b1; start = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0 || busy !== 1'b0 || hilo_we !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset got stall=%b busy=%b we=%b hi=%h lo=%h want all 0", stall, busy, hilo_we, hi, lo);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (hilo_we === 1'b1) we_seen++;
    end
    checks++;
    if (we_seen != 0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL mid_reset_quiet got we_count=%0d hi=%h lo=%h want 0/0/0", we_seen, hi, lo);
    end
    do_op("after_reset_divu", 2'b11, 32'd100, 32'd7);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cancel = 1'b0; op = 2'b00; a = '0; b = '0;
    #12;
    test_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    test_directed();
    test_cancel();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
